in_demux: RTL and testbench
===========================

IN_DEMUX -- requirements
Module: in_demux

Interface
REQ-001 The block SHALL have no parameters; lane count (3) and formats are fixed.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 enb  input  1  fast-rate clock enable; one serial sample per enb cycle.
REQ-005 sync_in  input  1  frame alignment; when high with enb, the sample in that cycle is treated as phase 0.
REQ-006 In1  input  11  signed serial sample, sfix11_En3.
REQ-007 Out1  output  36  signed lane-1 sample, sfix36_En27.
REQ-008 Out2  output  36  signed lane-2 sample, sfix36_En27.
REQ-009 Out3  output  36  signed lane-3 sample, sfix36_En27.
REQ-010 frame_valid  output  1  one-clk pulse when Out1..Out3 have just been updated with a new frame.

Function
REQ-011 A 2-bit phase counter SHALL count 0,1,2,0,... advancing only on enb; it wraps from 2 to 0.
REQ-012 On enb with sync_in=1, the sample SHALL be taken as phase 0 and the counter SHALL become 1, regardless of current phase.
REQ-013 Phase mapping SHALL be phase 0 -> lane 3, phase 1 -> lane 2, phase 2 -> lane 1, matching the downstream output mux order (lane 3 emitted first).
REQ-014 Samples at phases 0 and 1 SHALL be held in two internal capture registers.
REQ-015 On enb at phase 2, Out3, Out2, Out1 SHALL load simultaneously from phase-0 capture, phase-1 capture, and the current In1, visible the next clk edge.
REQ-016 frame_valid SHALL be high for exactly the one clk cycle following the edge that loads Out1..Out3, and low otherwise.
REQ-017 Format conversion SHALL be lossless: output bits [34:24] = sample, bit 35 = sample sign, bits [23:0] = 0 (value preserved; no rounding or saturation).
REQ-018 With enb low, counter, captures, outputs SHALL hold and frame_valid SHALL be 0.
REQ-019 A sync_in at phase 1 or 2 SHALL discard the partial frame; Out1..Out3 SHALL keep the last complete frame and no frame_valid SHALL be issued for it.
REQ-020 sync_in with enb at phase 0 SHALL have no effect beyond normal operation.
REQ-021 Latency from the phase-2 sample at In1 to Out1 SHALL be 1 clk (without REQ-027 option).

Reset
REQ-022 On reset, phase counter SHALL be 0, capture registers 0, Out1..Out3 36'sh0, frame_valid 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; the first enb sample after release is phase 0.
REQ-024 Reset SHALL act immediately, independent of clk and enb.

Configuration
REQ-025 Macro IN_DEMUX_INREG_EN SHALL control an input pipeline register.
REQ-026 Without IN_DEMUX_INREG_EN, In1 and sync_in SHALL be used directly as in REQ-011..REQ-021.
REQ-027 With IN_DEMUX_INREG_EN, In1 and sync_in SHALL be registered on enb (reset to 0) before the phase logic, adding exactly one enb sample of latency; all other behaviour unchanged.

Verification
REQ-028 Reset, enb=1 each clk, sync on first sample, In1 = 11'sd8, -11'sd16, 11'sd1023 -> Out3=36'sd134217728 (1.0), Out2=-36'sd268435456 (-2.0), Out1=36'sd17163091968 (127.875); frame_valid one pulse.
REQ-029 enb high every 3rd clk only, 6 samples -> two frame_valid pulses, each 1 clk wide, outputs stable between.
REQ-030 sync_in asserted at phase 2 of a frame -> no frame_valid for that frame, outputs keep prior frame, next 3 samples form a frame.
REQ-031 reset pulsed after phase-1 sample -> all outputs 0 immediately, next complete frame starts at first post-reset sample.
REQ-032 In1 = -11'sd1024 all phases -> all lanes = -36'sd17179869184 (-128.0), no overflow.
REQ-033 Build with IN_DEMUX_INREG_EN, repeat REQ-028 -> same values, frame_valid one enb sample later.

Source files
------------

// File: rtl/in_demux.sv
// in_demux: 3-lane serial-to-parallel demultiplexer for sfix11_En3 samples.
//   Every third enb sample completes a frame. Phase 0 goes to lane 3, phase 1 to
//   lane 2, and phase 2 to lane 1. All three lanes update together, widened
//   losslessly to sfix36_En27.
// Latency: 1 clk from the phase-2 sample to Out1..Out3 and frame_valid.
//   Building with IN_DEMUX_INREG_EN adds one more enb sample.
// Backpressure: none. The block consumes one sample per enb and holds all state while enb is low.
// Ports:
//   clk, reset (async, active-high), enb (sample strobe), sync_in (phase-0 marker),
//   In1 (sfix11_En3), Out1..Out3 (sfix36_En27), frame_valid (1-clk pulse per frame).
// Macro IN_DEMUX_INREG_EN: registers In1/sync_in on enb before the phase logic.
module in_demux (
  input  logic               clk,
  input  logic               reset,
  input  logic               enb,
  input  logic               sync_in,
  input  logic signed [10:0] In1,
  output logic signed [35:0] Out1,
  output logic signed [35:0] Out2,
  output logic signed [35:0] Out3,
  output logic               frame_valid
);

  logic signed [10:0] smp;
  logic               syn;

`ifdef IN_DEMUX_INREG_EN
  logic signed [10:0] in_q;
  logic               sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q   <= '0;
      sync_q <= 1'b0;
    end else if (enb) begin
      in_q   <= In1;
      sync_q <= sync_in;
    end
  end

  assign smp = in_q;
  assign syn = sync_q;
`else
  assign smp = In1;
  assign syn = sync_in;
`endif

  // Align the En3 binary point to En27 by shifting left 24 places.
  // Sign extension to 36 bits keeps the value exact.
  function automatic logic signed [35:0] widen(input logic signed [10:0] s);
    return {s[10], s, 24'b0};
  endfunction

  logic [1:0]         phase;
  logic signed [10:0] cap0;
  logic signed [10:0] cap1;

  // A sync sample always restarts the frame as phase 0. Any partial frame is
  // dropped. A sync sample arriving at phase 2 therefore never loads the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= 2'd0;
      cap0        <= '0;
      cap1        <= '0;
      Out1        <= '0;
      Out2        <= '0;
      Out3        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (enb) begin
        if (syn) begin
          cap0  <= smp;
          phase <= 2'd1;
        end else begin
          case (phase)
            2'd0: begin
              cap0  <= smp;
              phase <= 2'd1;
            end
            2'd1: begin
              cap1  <= smp;
              phase <= 2'd2;
            end
            2'd2: begin
              Out3        <= widen(cap0);
              Out2        <= widen(cap1);
              Out1        <= widen(smp);
              frame_valid <= 1'b1;
              phase       <= 2'd0;
            end
            default: phase <= 2'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_in_demux.sv
module tb_in_demux;

  logic               clk;
  logic               reset;
  logic               enb;
  logic               sync_in;
  logic signed [10:0] In1;
  logic signed [35:0] Out1;
  logic signed [35:0] Out2;
  logic signed [35:0] Out3;
  logic               frame_valid;

  in_demux dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .sync_in     (sync_in),
    .In1         (In1),
    .Out1        (Out1),
    .Out2        (Out2),
    .Out3        (Out3),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [35:0] o1;
    logic signed [35:0] o2;
    logic signed [35:0] o3;
  } frame_t;

  frame_t             exp_q[$];
  logic signed [35:0] held1, held2, held3;
  int                 errors = 0;
  int                 checks = 0;
  logic               prev_fv = 1'b0;

  task automatic chk(input string name, input logic signed [35:0] act, input logic signed [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic signed [35:0] o1, input logic signed [35:0] o2, input logic signed [35:0] o3);
    frame_t f;
    f.o1 = o1; f.o2 = o2; f.o3 = o3;
    exp_q.push_back(f);
  endtask

  // One enb sample, followed by 'gap' idle clocks with enb low.
  task automatic smp(input logic signed [10:0] v, input logic s, input int gap);
    enb = 1'b1; In1 = v; sync_in = s;
    @(posedge clk); #1;
    enb = 1'b0; sync_in = 1'b0; In1 = '0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop on every frame_valid, otherwise the outputs must hold the last frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        checks++;
        if (prev_fv) begin
          errors++;
          $display("FAIL fv_width: frame_valid high for 2 consecutive clks");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got Out1=%0d, expected no frame", Out1);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk("frame_out1", Out1, f.o1);
          chk("frame_out2", Out2, f.o2);
          chk("frame_out3", Out3, f.o3);
          held1 = f.o1; held2 = f.o2; held3 = f.o3;
        end
      end else begin
        chk("hold_out1", Out1, held1);
        chk("hold_out2", Out2, held2);
        chk("hold_out3", Out3, held3);
      end
      prev_fv <= frame_valid;
    end else begin
      prev_fv <= 1'b0;
    end
  end

  initial begin
    held1 = '0; held2 = '0; held3 = '0;
    enb = 1'b0; sync_in = 1'b0; In1 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out1", Out1, 36'sd0);
    chk("reset_out2", Out2, 36'sd0);
    chk("reset_out3", Out3, 36'sd0);
    chk("reset_fv", {35'd0, frame_valid}, 36'sd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic frame, sync on the first sample: 1.0, -2.0, 127.875.
    push(36'sd17163091968, -36'sd268435456, 36'sd134217728);
    smp(11'sd8, 1'b1, 0);
    smp(-11'sd16, 1'b0, 0);
    smp(11'sd1023, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end

    // enb on every third clk only: two frames.
    push(36'sd50331648, 36'sd33554432, 36'sd16777216);
    smp(11'sd1, 1'b0, 2);
    smp(11'sd2, 1'b0, 2);
    smp(11'sd3, 1'b0, 2);
    push(-36'sd50331648, -36'sd33554432, -36'sd16777216);
    smp(-11'sd1, 1'b0, 2);
    smp(-11'sd2, 1'b0, 2);
    smp(-11'sd3, 1'b0, 2);

    // A sync at phase 2 drops the partial frame (5, 6). Sample 7 starts the new frame.
    smp(11'sd5, 1'b0, 0);
    smp(11'sd6, 1'b0, 0);
    push(36'sd167772160, 36'sd150994944, 36'sd117440512);
    smp(11'sd7, 1'b1, 0);
    smp(11'sd9, 1'b0, 0);
    smp(11'sd10, 1'b0, 1);

    // Reset after the phase-1 sample: outputs clear immediately, and the frame restarts.
    smp(11'sd4, 1'b0, 0);
    smp(11'sd4, 1'b0, 0);
    #2;
    reset = 1'b1;
    held1 = '0; held2 = '0; held3 = '0;
    #1;
    chk("midreset_out1", Out1, 36'sd0);
    chk("midreset_out2", Out2, 36'sd0);
    chk("midreset_out3", Out3, 36'sd0);
    chk("midreset_fv", {35'd0, frame_valid}, 36'sd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    push(-36'sd134217728, -36'sd67108864, 36'sd33554432);
    smp(11'sd2, 1'b0, 0);
    smp(-11'sd4, 1'b0, 0);
    smp(-11'sd8, 1'b0, 1);

    // Most-negative input on every lane.
    push(-36'sd17179869184, -36'sd17179869184, -36'sd17179869184);
    smp(-11'sd1024, 1'b0, 0);
    smp(-11'sd1024, 1'b0, 0);
    smp(-11'sd1024, 1'b0, 1);

    // A sync at phase 0 behaves like normal operation.
    push(-36'sd16777216, 36'sd0, 36'sd50331648);
    smp(11'sd3, 1'b1, 0);
    smp(11'sd0, 1'b0, 0);
    smp(-11'sd1, 1'b0, 0);

    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames: got %0d frames outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
